// File: rtl/dm_port_arbiter_if.sv
// Handshake/bus bundle for dm_port_arbiter: two requester ports plus the
// memory-side port. The slave modport is the arbiter's view; the master
// modport is the requesters' and memory's view.
interface dm_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req0;
  logic              wr0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              wr1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  logic [DATA_W-1:0] rdata1;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_write;
  logic              mem_read;
  logic [DATA_W-1:0] mem_read_data;

  logic              busy;

  modport slave (
    input  req0, wr0, addr0, wdata0,
    input  req1, wr1, addr1, wdata1,
    input  mem_read_data,
    output ack0, rdata0, ack1, rdata1,
    output mem_address, mem_write_data, mem_write, mem_read,
    output busy
  );

  modport master (
    output req0, wr0, addr0, wdata0,
    output req1, wr1, addr1, wdata1,
    output mem_read_data,
    input  ack0, rdata0, ack1, rdata1,
    input  mem_address, mem_write_data, mem_write, mem_read,
    input  busy
  );
endinterface

// File: rtl/dm_port_arbiter.sv
// Two-requester arbiter in front of a single data memory (sync write,
// combinational read). One access at a time: IDLE picks a winner, ACCESS
// drives the memory for one cycle, DONE pulses the winner's ack.
module dm_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RR     = 1
) (
  input logic              clk,
  input logic              rst,
  dm_port_arbiter_if.slave bus
);

  localparam logic RR_EN = (RR != 0);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t state;
  logic   gnt;   // granted requester index
  logic   last;  // requester served most recently (round-robin pointer)
  logic   win;

  logic              wr_g;
  logic [ADDR_W-1:0] addr_g;
  logic [DATA_W-1:0] wdata_g;

  // Winner selection; only consumed in IDLE when at least one request is up.
  always_comb begin
    win = bus.req1;
    if (bus.req0 && bus.req1) win = RR_EN ? ~last : 1'b0;
  end

  // Mux of the granted requester's command.
  always_comb begin
    wr_g    = gnt ? bus.wr1    : bus.wr0;
    addr_g  = gnt ? bus.addr1  : bus.addr0;
    wdata_g = gnt ? bus.wdata1 : bus.wdata0;
  end

  // Memory port is only live in ACCESS; decoding from state makes reset
  // drop MemWrite at once, so an interrupted write never commits.
  always_comb begin
    bus.mem_address    = '0;
    bus.mem_write_data = '0;
    bus.mem_write      = 1'b0;
    bus.mem_read       = 1'b0;
    if (state == ACCESS) begin
      bus.mem_address    = addr_g;
      bus.mem_write_data = wdata_g;
      bus.mem_write      = wr_g;
      bus.mem_read       = ~wr_g;
    end
  end

  assign bus.busy = (state != IDLE);

  // Arbitration FSM with registered grant, acks and read-data returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      gnt        <= 1'b0;
      last       <= 1'b1;
      bus.ack0   <= 1'b0;
      bus.ack1   <= 1'b0;
      bus.rdata0 <= '0;
      bus.rdata1 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            gnt   <= win;
            state <= ACCESS;
          end
        end
        ACCESS: begin
          last <= gnt;
          if (!wr_g) begin
            if (gnt) bus.rdata1 <= bus.mem_read_data;
            else     bus.rdata0 <= bus.mem_read_data;
          end
          bus.ack0 <= ~gnt;
          bus.ack1 <= gnt;
          state    <= DONE;
        end
        DONE: begin
          // No arbitration here: a request still high during its ack is
          // the same command and must not be served twice.
          bus.ack0 <= 1'b0;
          bus.ack1 <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: memory model, two requester drivers, and a
// scoreboard that replays completed accesses into a reference memory in
// ack order and checks returned read data.
module tb_dm_port_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dm_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  dm_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_fp();

  dm_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR(1)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  dm_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR(0)) dut_fp (
    .clk(clk), .rst(rst), .bus(bus_fp)
  );

  // Data memory attached to the round-robin instance.
  logic [DW-1:0] mem [256];
  always @(posedge clk) if (bus.mem_write) mem[bus.mem_address] <= bus.mem_write_data;
  assign bus.mem_read_data    = bus.mem_read ? mem[bus.mem_address] : '0;
  assign bus_fp.mem_read_data = '0;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  cmd_t          exp_q0[$];
  cmd_t          exp_q1[$];
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] ref_rd0 = '0;
  logic [DW-1:0] ref_rd1 = '0;
  int            gnt_log[$];
  int            gnt_cyc[$];

  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int acc_cnt = 0;
  int ack_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Retire one completed access for requester k into the reference model.
  task automatic retire(input int k);
    cmd_t c;
    checks++;
    if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
      errors++;
      $display("FAIL spurious_ack%0d: got ack expected none at cycle %0d", k, cyc);
      return;
    end
    c = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
    if (c.wr) ref_mem[c.addr] = c.wdata;
    else if (k == 0) ref_rd0 = ref_mem[c.addr];
    else ref_rd1 = ref_mem[c.addr];
    chk("rdata0", bus.rdata0, ref_rd0);
    chk("rdata1", bus.rdata1, ref_rd1);
    gnt_log.push_back(k);
    gnt_cyc.push_back(cyc);
    ack_cnt++;
  endtask

  // Monitor: samples between edges, pops the scoreboard on each ack.
  always @(negedge clk) begin
    if (rst) begin
      ref_rd0 = '0;
      ref_rd1 = '0;
    end else begin
      if (bus.mem_write || bus.mem_read) acc_cnt++;
      else if (bus.mem_address != '0 || bus.mem_write_data != '0)
        chk("mem_idle_zero", {bus.mem_address, bus.mem_write_data}, 32'h0);
      if (bus.ack0 && bus.ack1) chk("ack_exclusive", {bus.ack0, bus.ack1}, 32'h0);
      if (bus.ack0) retire(0);
      if (bus.ack1) retire(1);
    end
  end

  // Present one command, wait (bounded) for its ack, drop req after it.
  task automatic issue(input int k, input logic wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input int exp_lat);
    cmd_t c;
    int   n;
    logic got;
    c = '{wr, addr, wdata};
    if (k == 0) begin
      exp_q0.push_back(c);
      bus.wr0 = wr; bus.addr0 = addr; bus.wdata0 = wdata; bus.req0 = 1'b1;
    end else begin
      exp_q1.push_back(c);
      bus.wr1 = wr; bus.addr1 = addr; bus.wdata1 = wdata; bus.req1 = 1'b1;
    end
    n = 0;
    got = 1'b0;
    while (!got && n < 30) begin
      @(negedge clk);
      n++;
      got = (k == 0) ? bus.ack0 : bus.ack1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ack_timeout%0d: got no ack expected ack within 30 cycles", k);
    end else if (exp_lat > 0 && n != exp_lat) begin
      errors++;
      $display("FAIL latency%0d: got %0d expected %0d", k, n, exp_lat);
    end
    @(posedge clk);
    #1;
    if (k == 0) bus.req0 = 1'b0;
    else bus.req1 = 1'b0;
  endtask

  function automatic logic [AW-1:0] pick_addr();
    case ($urandom_range(0, 3))
      0: return 8'h00;
      1: return 8'h10;
      2: return 8'h20;
      default: return 8'hFF;
    endcase
  endfunction

  task automatic rand_req(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      issue(k, 1'($urandom_range(0, 1)), pick_addr(), 8'($urandom), 0);
    end
  endtask

  initial begin
    int n0, n1;
    logic got;
    bus.req0 = 0; bus.wr0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 0; bus.wr1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
    bus_fp.req0 = 0; bus_fp.wr0 = 1; bus_fp.addr0 = '0; bus_fp.wdata0 = '0;
    bus_fp.req1 = 0; bus_fp.wr1 = 1; bus_fp.addr1 = '0; bus_fp.wdata1 = '0;

    // Reset state
    #1;
    chk("rst_ack", {bus.ack0, bus.ack1}, 32'h0);
    chk("rst_rdata", {bus.rdata0, bus.rdata1}, 32'h0);
    chk("rst_mem", {bus.mem_write, bus.mem_read, bus.mem_address, bus.mem_write_data}, 32'h0);
    chk("rst_busy", bus.busy, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Both requesters hold requests from reset: grants alternate 0,1,0,1,
    // one ack every 3 cycles. These writes also seed the addresses used later.
    fork
      begin
        issue(0, 1'b1, 8'h00, 8'h5A, 0); issue(0, 1'b1, 8'h10, 8'h66, 0);
        issue(0, 1'b1, 8'h20, 8'h77, 0); issue(0, 1'b1, 8'hFF, 8'h88, 0);
      end
      begin
        issue(1, 1'b1, 8'h10, 8'h21, 0); issue(1, 1'b1, 8'h20, 8'h32, 0);
        issue(1, 1'b1, 8'hFF, 8'h43, 0); issue(1, 1'b1, 8'h00, 8'h54, 0);
      end
    join
    chk("rr_count", gnt_log.size(), 32'd8);
    for (int i = 0; i < 8 && i < gnt_log.size(); i++) begin
      chk("rr_order", gnt_log[i], i % 2);
      if (i > 0) chk("rr_spacing", gnt_cyc[i] - gnt_cyc[i-1], 32'd3);
    end

    // Write then read back, single requester, 3-cycle latency each.
    issue(0, 1'b1, 8'h10, 8'h3C, 3);
    issue(0, 1'b0, 8'h10, 8'h00, 3);
    chk("rd_0x10", bus.rdata0, 32'h3C);
    chk("one_access_per_ack", acc_cnt, ack_cnt);

    // Cross-requester: R1 writes 0xFF, R0 reads it; R1's rdata untouched.
    issue(1, 1'b1, 8'hFF, 8'hA5, 3);
    issue(0, 1'b0, 8'hFF, 8'h00, 3);
    chk("rd_0xFF", bus.rdata0, 32'hA5);
    chk("rdata1_hold", bus.rdata1, 32'h00);

    // Randomised concurrent traffic.
    fork
      rand_req(0, 25);
      rand_req(1, 25);
    join

    // Reset in the middle of a write ACCESS: the write must not land.
    issue(0, 1'b1, 8'h20, 8'h11, 3);
    bus.wr0 = 1'b1; bus.addr0 = 8'h20; bus.wdata0 = 8'h77; bus.req0 = 1'b1;
    @(posedge clk); #1;
    chk("access_mem_write", {bus.mem_write, bus.mem_address}, {1'b1, 8'h20});
    rst = 1'b1;
    #1;
    chk("midrst_mem", {bus.mem_write, bus.mem_read, bus.mem_address, bus.mem_write_data}, 32'h0);
    chk("midrst_busy", bus.busy, 32'h0);
    chk("midrst_ack", {bus.ack0, bus.ack1}, 32'h0);
    chk("midrst_rdata", {bus.rdata0, bus.rdata1}, 32'h0);
    bus.req0 = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    issue(0, 1'b0, 8'h20, 8'h00, 3);
    chk("rd_after_abort", bus.rdata0, 32'h11);

    // Fixed priority: requester 1 starves while requester 0 keeps asking.
    bus_fp.req0 = 1'b1; bus_fp.req1 = 1'b1;
    n0 = 0; n1 = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus_fp.ack0) n0++;
      if (bus_fp.ack1) n1++;
    end
    chk("fp_ack0_count", n0, 32'd4);
    chk("fp_ack1_starved", n1, 32'd0);
    @(posedge clk); #1;
    bus_fp.req0 = 1'b0;
    got = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus_fp.ack1) got = 1'b1;
    end
    chk("fp_ack1_after_drop", got, 32'd1);
    bus_fp.req1 = 1'b0;

    repeat (4) @(posedge clk);
    #1;
    chk("access_total", acc_cnt, ack_cnt);
    chk("queues_drained", exp_q0.size() + exp_q1.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
